// File: rtl/lfsr_stream_gen.sv
// Galois LFSR word source with a valid/ready output, runtime seed load and a
// wrap pulse marking each return to the stored seed.
module lfsr_stream_gen #(
  parameter int          WIDTH        = 32,
  parameter logic [63:0] DEFAULT_SEED = 64'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_seed_valid,
  input  logic [WIDTH-1:0] i_seed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_wrapped
);

  localparam logic [63:0] MASK64 =
    (WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
    (WIDTH == 16) ? 64'h0000_0000_0000_B400 :
    (WIDTH == 24) ? 64'h0000_0000_00E1_0000 :
    (WIDTH == 32) ? 64'h0000_0000_A300_0000 :
                    64'hD800_0000_0000_0000;

  localparam logic [WIDTH-1:0] MASK = WIDTH'(MASK64);
  localparam logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("lfsr_stream_gen: unsupported WIDTH %0d", WIDTH);
  end

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_stream_gen: DEFAULT_SEED truncates to zero");
  end

  logic [WIDTH-1:0] state, stored_seed;
  logic [WIDTH-1:0] step, load_val;
  logic             accept;

  always_comb begin
    step     = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? MASK : '0);
    // An all-zero seed would lock the register, so it is replaced on load.
    load_val = (i_seed == '0) ? SEED : i_seed;
    accept   = o_valid & i_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEED;
      stored_seed <= SEED;
      o_valid     <= 1'b0;
      o_wrapped   <= 1'b0;
    end else if (i_seed_valid) begin
      // Load flushes the offered word and swallows any same-cycle accept.
      state       <= load_val;
      stored_seed <= load_val;
      o_valid     <= 1'b0;
      o_wrapped   <= 1'b0;
    end else if (accept) begin
      state       <= step;
      o_valid     <= i_enable;
      o_wrapped   <= (step == stored_seed);
    end else begin
      o_wrapped   <= 1'b0;
      // An offered word stays up until taken, even if enable drops.
      if (!o_valid) o_valid <= i_enable;
    end
  end

  assign o_data = state;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Scoreboard bench: stimulus queues hand-computed words, negedge monitors pop
// and compare on every accepted word for a 32-bit and an 8-bit instance.
module tb_lfsr_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en32, sv32, rdy32, v32, w32;
  logic [31:0] seed32, d32;
  logic        en8, sv8, rdy8, v8, w8;
  logic [7:0]  seed8, d8;

  int n_tests = 0;
  int n_fail  = 0;
  int acc32   = 0;
  int acc8    = 0;
  int wrap8   = 0;
  logic [31:0] q32[$];
  logic [7:0]  q8[$];

  lfsr_stream_gen #(.WIDTH(32), .DEFAULT_SEED(64'd1)) dut32 (
    .clk(clk), .reset_n(reset_n), .i_enable(en32), .i_seed_valid(sv32),
    .i_seed(seed32), .o_valid(v32), .i_ready(rdy32), .o_data(d32),
    .o_wrapped(w32));

  lfsr_stream_gen #(.WIDTH(8), .DEFAULT_SEED(64'd1)) dut8 (
    .clk(clk), .reset_n(reset_n), .i_enable(en8), .i_seed_valid(sv8),
    .i_seed(seed8), .o_valid(v8), .i_ready(rdy8), .o_data(d8),
    .o_wrapped(w8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: an accept is valid & ready without a concurrent seed load.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("wrap32_idle", {63'd0, w32}, 64'd0);
      if (v32 && rdy32 && !sv32) begin
        if (q32.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra32: got word %h, expected none", d32);
        end else begin
          chk("data32", {32'd0, d32}, {32'd0, q32.pop_front()});
        end
        acc32++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (w8) begin
        wrap8++;
        chk("wrap8_pos", 64'(acc8), 64'd255);
        chk("wrap8_data", {56'd0, d8}, 64'h01);
      end
      if (v8 && rdy8 && !sv8) begin
        if (q8.size() != 0) chk("data8", {56'd0, d8}, {56'd0, q8.pop_front()});
        acc8++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input int target);
    for (int k = 0; k < 100 && acc32 < target; k++) tick();
    chk("run32_done", {63'd0, acc32 >= target}, 64'd1);
  endtask

  task automatic run8(input int target);
    for (int k = 0; k < 400 && acc8 < target; k++) tick();
    chk("run8_done", {63'd0, acc8 >= target}, 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    en32 = 0; sv32 = 0; rdy32 = 0; seed32 = '0;
    en8  = 0; sv8  = 0; rdy8  = 0; seed8  = '0;
    #12;
    chk("rst_valid32", {63'd0, v32}, 64'd0);
    chk("rst_wrap32",  {63'd0, w32}, 64'd0);
    chk("rst_data32",  {32'd0, d32}, 64'h1);
    chk("rst_valid8",  {63'd0, v8},  64'd0);
    chk("rst_data8",   {56'd0, d8},  64'h1);

    // First words after reset, back-to-back.
    @(posedge clk); #1;
    reset_n = 1'b1; en32 = 1; rdy32 = 1;
    q32.push_back(32'h0000_0001); q32.push_back(32'hA300_0000);
    q32.push_back(32'h5180_0000); q32.push_back(32'h28C0_0000);
    chk("lat_pre", {63'd0, v32}, 64'd0);
    tick();
    chk("lat_valid", {63'd0, v32}, 64'd1);
    run32(4);
    rdy32 = 0;

    // Backpressure: word held through a stall while enable drops.
    q32.push_back(32'h1460_0000);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) en32 = 0;
      tick();
      chk("stall_valid", {63'd0, v32}, 64'd1);
      chk("stall_data", {32'd0, d32}, 64'h1460_0000);
    end
    rdy32 = 1;
    run32(5);
    chk("bp_drop", {63'd0, v32}, 64'd0);
    tick();
    chk("bp_idle", {63'd0, v32}, 64'd0);
    rdy32 = 0;

    // Zero seed load with a concurrent accept.
    en32 = 1;
    tick();
    chk("pre_zero_valid", {63'd0, v32}, 64'd1);
    chk("pre_zero_data", {32'd0, d32}, 64'h0A30_0000);
    rdy32 = 1; sv32 = 1; seed32 = 32'h0;
    tick();
    sv32 = 0;
    chk("zero_flush", {63'd0, v32}, 64'd0);
    chk("zero_subst", {32'd0, d32}, 64'h1);
    chk("zero_nowrap", {63'd0, w32}, 64'd0);
    q32.push_back(32'h0000_0001); q32.push_back(32'hA300_0000);
    run32(7);
    rdy32 = 0;

    // Seed load wins over a simultaneous accept.
    rdy32 = 1; sv32 = 1; seed32 = 32'hDEAD_BEEF;
    tick();
    sv32 = 0;
    chk("load_flush", {63'd0, v32}, 64'd0);
    chk("load_data", {32'd0, d32}, 64'hDEAD_BEEF);
    q32.push_back(32'hDEAD_BEEF); q32.push_back(32'hCC56_DF77);
    run32(9);
    rdy32 = 0;

    // 8-bit full period from seed 0x01.
    sv8 = 1; seed8 = 8'h01;
    tick();
    sv8 = 0; en8 = 1; rdy8 = 1;
    q8.push_back(8'h01); q8.push_back(8'hB8); q8.push_back(8'h5C);
    q8.push_back(8'h2E); q8.push_back(8'h17); q8.push_back(8'hB3);
    run8(256);
    en8 = 0; rdy8 = 0;
    tick(); tick();

    // Asynchronous reset between edges while a word is offered.
    chk("pre_rst_valid", {63'd0, v32}, 64'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_valid", {63'd0, v32}, 64'd0);
    chk("async_wrap", {63'd0, w32}, 64'd0);
    chk("async_data", {32'd0, d32}, 64'h1);
    @(posedge clk); #1;
    reset_n = 1'b1; en32 = 1; rdy32 = 1;
    q32.push_back(32'h0000_0001); q32.push_back(32'hA300_0000);
    q32.push_back(32'h5180_0000);
    run32(12);
    rdy32 = 0; en32 = 0;
    tick(); tick(); tick();

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("wrap8_count", 64'(wrap8), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_gen.md
Name: lfsr_stream_gen

Overview:
- Parametrised Galois LFSR pseudo-random source for the arithmetic testbench. Generalises the fixed 32-bit randomiser to selectable widths.
- Adds a valid/ready output stream, so the sequence advances only on accepted words.
- Runtime seed load with zero-seed lock-up protection.
- Period-wrap detection pulse.
- Feeds operand generators / DUT stimulus paths.

Parameters:
- WIDTH, 32, LFSR and data width. Supported: 8, 16, 24, 32, 64. Any other value is an elaboration-time error.
- DEFAULT_SEED, 1, reset seed and substitute for an all-zero seed. Must be non-zero, truncated to WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  request generation; 0 = stop offering new words.
- i_seed_valid  in  1  load i_seed this cycle.
- i_seed  in  WIDTH  seed value.
- o_valid  out  1  o_data holds an offered word.
- i_ready  in  1  consumer accepts o_data when o_valid=1.
- o_data  out  WIDTH  current LFSR state.
- o_wrapped  out  1  one-cycle pulse: sequence returned to the stored seed.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state = DEFAULT_SEED, stored_seed = DEFAULT_SEED.
  - o_valid = 0, o_wrapped = 0.
  - o_data always equals state.
- Step function (Galois, right shift): next = (state >> 1) ^ (state[0] ? MASK : 0).
- MASK per WIDTH:
  - 8: 0xB8 (taps 8,6,5,4).
  - 16: 0xB400.
  - 24: 0xE10000.
  - 32: 0xA3000000 (taps 32,30,26,25).
  - 64: 0xD800000000000000.
- Accept: o_valid & i_ready at a rising edge.
- Priority at each edge:
  1. Seed load (i_seed_valid=1):
     - state <= (i_seed==0 ? DEFAULT_SEED : i_seed); stored_seed <= same value.
     - o_valid <= 0 for that cycle (flush). This is the only case where an offered word is withdrawn unaccepted.
     - Any concurrent accept is discarded: no advance, no o_wrapped.
  2. Accept:
     - state <= next.
     - o_valid <= i_enable.
     - o_wrapped <= (next == stored_seed).
  3. Otherwise:
     - state holds.
     - If o_valid=0, o_valid <= i_enable.
     - If o_valid=1, o_valid stays 1 regardless of i_enable; o_data must be stable until accepted.
- o_wrapped:
  - Registered; high exactly one cycle after the accepting edge, else 0.
  - Fires every 2^WIDTH-1 accepts from a seed load or reset.
- Latency:
  - i_enable rise → o_valid=1 on the next edge.
  - Back-to-back accepts with i_ready held 1: one new word per cycle, no bubbles.
- State is never zero in operation; zero seeds are substituted on load.
- i_enable low with o_valid=0: no activity, state held indefinitely.
- reset_n asserted mid-stream: immediate return to reset values; the pending word is lost.

Test Plan:
- WIDTH=32, reset, i_enable=1, i_ready=1 → o_valid rises 1 cycle later; o_data sequence 0x00000001, 0xA3000000, 0x51800000, 0x28C00000.
- WIDTH=8, seed load 0x01, continuous accept → 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3. o_wrapped pulses exactly once after the 255th accept, when o_data returns to 0x01.
- Backpressure: i_ready=0 for 5 cycles with o_valid=1, i_enable dropped mid-stall → o_valid and o_data held constant. On i_ready=1 the word is accepted once, then o_valid=0.
- Seed load 0x00000000 (WIDTH=32) → state = DEFAULT_SEED (0x1), o_valid=0 for one cycle. Concurrent accept discarded, no o_wrapped.
- Seed load 0xDEADBEEF simultaneous with accept → load wins; next offered word is 0xDEADBEEF, then 0xDEADBEEF>>1 ^ 0xA3000000 = 0xCC56DF77.
- reset_n pulsed low mid-stream (asynchronously, between edges) → o_valid, o_wrapped drop to 0 immediately; o_data = 0x1. Sequence restarts from 0x1 after release.
